// File: rtl/urecv_pkg.sv
// Shared definitions for the urecv serial receiver: FSM state encodings and the
// two ASCII codes that are turned into back_sp instead of ds.
package urecv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    function automatic logic is_erase(input logic [7:0] b);
        return (b == ASCII_BS) || (b == ASCII_DEL);
    endfunction

endpackage

// File: rtl/urecv_tick.sv
// Oversample tick generator: one-clk tick every DIV clks, with a synchronous clear
// so the receiver can phase-align ticks to the start-bit edge.
module urecv_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clr)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/urecv.sv
// RS-232 receiver (8N1, LSB first; 8E1 when URECV_PARITY_EN is defined) producing
// texter-compatible ascii_out/ds/back_sp strobes plus frame_err/par_err diagnostics.
module urecv
    import urecv_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sin,
    output logic [7:0] ascii_out,
    output logic       ds,
    output logic       back_sp,
    output logic       frame_err,
    output logic       par_err,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / (BAUD * OVS);
    localparam int CNT_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);

    state_t           state, state_next;
    logic             sin_m, sin_s;
    logic             armed;
    logic             tick, tick_clr;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       ascii_next;
    logic             ds_next, bs_next, fe_next, pe_next;

    urecv_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

`ifdef URECV_PARITY_EN
    logic par_mismatch, par_mismatch_next;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        ascii_next    = ascii_out;
        ds_next       = 1'b0;
        bs_next       = 1'b0;
        fe_next       = 1'b0;
        pe_next       = 1'b0;
        tick_clr      = 1'b0;
`ifdef URECV_PARITY_EN
        par_mismatch_next = par_mismatch;
`endif
        case (state)
            IDLE: if (armed && !sin_s) begin
                state_next    = START;
                tick_clr      = 1'b1;
                tick_cnt_next = '0;
            end
            START: if (tick) begin
                if (tick_cnt == HALF_LAST) begin
                    tick_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = sin_s ? IDLE : DATA;
                end else begin
                    tick_cnt_next = tick_cnt + 1'b1;
                end
            end
            DATA: if (tick) begin
                if (tick_cnt == BIT_LAST) begin
                    tick_cnt_next = '0;
                    shift_next    = {sin_s, shift[7:1]};
                    bit_idx_next  = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
`ifdef URECV_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                end else begin
                    tick_cnt_next = tick_cnt + 1'b1;
                end
            end
`ifdef URECV_PARITY_EN
            PARITY: if (tick) begin
                if (tick_cnt == BIT_LAST) begin
                    tick_cnt_next     = '0;
                    par_mismatch_next = ^{shift, sin_s};
                    state_next        = STOP;
                end else begin
                    tick_cnt_next = tick_cnt + 1'b1;
                end
            end
`endif
            STOP: if (tick) begin
                if (tick_cnt == BIT_LAST) begin
                    tick_cnt_next = '0;
                    if (sin_s) begin
                        if (is_erase(shift)) begin
                            bs_next = 1'b1;
                        end else begin
                            ds_next    = 1'b1;
                            ascii_next = shift;
                        end
`ifdef URECV_PARITY_EN
                        pe_next = par_mismatch;
`endif
                        state_next = IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    tick_cnt_next = tick_cnt + 1'b1;
                end
            end
            BREAK: if (sin_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sin_m     <= 1'b1;
            sin_s     <= 1'b1;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            ascii_out <= 8'h00;
            ds        <= 1'b0;
            back_sp   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            sin_m     <= sin;
            sin_s     <= sin_m;
            // A line held low since reset must go high once before any start bit counts.
            if (state == IDLE && sin_s)
                armed <= 1'b1;
            tick_cnt  <= tick_cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            ascii_out <= ascii_next;
            ds        <= ds_next;
            back_sp   <= bs_next;
            frame_err <= fe_next;
        end
    end

`ifdef URECV_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_mismatch <= 1'b0;
            par_err      <= 1'b0;
        end else begin
            par_mismatch <= par_mismatch_next;
            par_err      <= pe_next;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_urecv.sv
// Scoreboard bench for urecv: frames are driven bit by bit, a reference model
// predicts the strobe/ascii_out response, and a monitor checks each strobe cycle.
module tb_urecv;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int OVS    = 16;
    localparam int BIT    = (CLK_HZ / (BAUD * OVS)) * OVS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sin = 1'b1;
    logic [7:0] ascii_out;
    logic       ds, back_sp, frame_err, par_err, busy;

    urecv #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .ascii_out (ascii_out),
        .ds        (ds),
        .back_sp   (back_sp),
        .frame_err (frame_err),
        .par_err   (par_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // strobes = {ds, back_sp, frame_err, par_err}
    typedef struct packed {
        logic [3:0] strobes;
        logic [7:0] ascii;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_ascii = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        exp_t e;
        if (!stop) begin
            e.strobes = 4'b0010;
            e.ascii   = model_ascii;
        end else if (d == 8'h08 || d == 8'h7F) begin
            e.strobes = {3'b010, bad_par};
            e.ascii   = model_ascii;
        end else begin
            model_ascii = d;
            e.strobes   = {3'b100, bad_par};
            e.ascii     = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        logic pe;
`ifdef URECV_PARITY_EN
        pe = flip;
`else
        pe = 1'b0;
`endif
        expect_frame(d, stop, pe);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef URECV_PARITY_EN
        send_bit((^d) ^ flip);
`endif
        send_bit(stop);
    endtask

    always @(negedge clk) begin
        if (reset && (ds || back_sp || frame_err || par_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {28'h0, ds, back_sp, frame_err, par_err}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobes", {28'h0, ds, back_sp, frame_err, par_err}, {28'h0, mon_e.strobes});
                check("ascii_out", {24'h0, ascii_out}, {24'h0, mon_e.ascii});
            end
        end
    end

    logic [7:0] rd;
    logic       rstop;
    logic [7:0] aborted;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_state", {19'h0, ascii_out, busy, ds, back_sp, frame_err, par_err}, 32'h0);
        reset = 1'b1;
        idle(BIT);

        // 'A' then busy must be low once the stop bit has passed
        send_frame(8'h41, 1'b1, 1'b0);
        check("busy_after_A", {31'h0, busy}, 32'h0);
        check("ascii_A", {24'h0, ascii_out}, 32'h41);

        // erase codes leave ascii_out alone
        send_frame(8'h08, 1'b1, 1'b0);
        send_frame(8'h7F, 1'b1, 1'b0);
        idle(BIT);
        check("ascii_after_erase", {24'h0, ascii_out}, 32'h41);

        // short glitch is a false start
        sin = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_in_glitch", {31'h0, busy}, 32'h1);
        repeat (90) @(negedge clk);
        idle(BIT);
        check("busy_after_glitch", {31'h0, busy}, 32'h0);

        // framing error, line break, then recovery
        send_frame(8'h55, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        idle(BIT);
        check("ascii_after_ferr", {24'h0, ascii_out}, 32'h41);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(BIT);
        check("ascii_5A", {24'h0, ascii_out}, 32'h5A);

        // reset in data bit 4 of 0x33 with the line held low across release
        aborted = 8'h33;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(aborted[i]);
        sin = aborted[4];
        repeat (BIT / 2) @(negedge clk);
        sin = 1'b0;
        reset = 1'b0;
        model_ascii = 8'h00;
        repeat (20) @(negedge clk);
        check("ascii_in_reset", {23'h0, ascii_out, busy}, 32'h0);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        idle(2 * BIT);
        check("busy_after_reset", {31'h0, busy}, 32'h0);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(BIT);
        check("ascii_34", {24'h0, ascii_out}, 32'h34);

`ifdef URECV_PARITY_EN
        send_frame(8'h41, 1'b1, 1'b1);
        send_frame(8'h41, 1'b1, 1'b0);
        idle(BIT);
`endif

        // randomized frames, including erase codes, bad stops and zero idle gaps
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0)
                rd = $urandom_range(0, 1) ? 8'h08 : 8'h7F;
            else
                rd = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rd, rstop, 1'b0);
            if (!rstop) begin
                send_bit(1'b0);
                send_bit(1'b0);
                idle(BIT);
            end else if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 60));
            end
        end

        idle(2 * BIT);
        check("queue_drained", exp_q.size(), 32'h0);
        check("ascii_final", {24'h0, ascii_out}, {24'h0, model_ascii});
        check("busy_final", {31'h0, busy}, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
